// File: rtl/rx_timer_pkg.sv
// Shared definitions for the receive bit-timing controller.
//   rx_timer_state_t    : frame-sequencing FSM states.
//   timer_params_legal  : elaboration-time legality check for the timer
//                         parameters. The top instantiates it and stops
//                         elaboration when the parameters are illegal.
package rx_timer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } rx_timer_state_t;

  function automatic bit timer_params_legal(input int clks_per_bit,
                                            input int sample_point,
                                            input int data_bits);
    return (clks_per_bit >= 2) && (clks_per_bit <= 255) &&
           (sample_point >= 1) && (sample_point <= clks_per_bit) &&
           (data_bits >= 1) && (data_bits <= 15);
  endfunction

endpackage

// File: rtl/bit_cycle_counter.sv
// Wrap-around cycle counter that runs 1..max_val.
//   clk, n_rst : clock and asynchronous active-low reset (count -> 0)
//   clear      : synchronous clear to 0 (highest priority)
//   load_one   : synchronous load of 1
//   en         : advance; wraps from max_val back to 1
//   max_val    : runtime wrap point
//   count      : current count
//   at_max     : count == max_val
module bit_cycle_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clear,
  input  logic         load_one,
  input  logic         en,
  input  logic [W-1:0] max_val,
  output logic [W-1:0] count,
  output logic         at_max
);

  assign at_max = (count == max_val);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load_one) begin
      count <= W'(1);
    end else if (en) begin
      // Counting is 1-based, so wrap goes to 1 rather than 0.
      count <= at_max ? W'(1) : W'(count + W'(1));
    end
  end

endmodule

// File: rtl/rx_bit_timer.sv
// Bit-timing controller for the serial receive path.
// A start-detect pulse launches a frame: one start bit, DATA_BITS data
// bits and a stop bit, each CLKS_PER_BIT cycles long. The stop bit is
// cut short at its sample point so the start detector can resync early.
//   clk, n_rst     : clock, asynchronous active-low reset
//   start_detected : one-cycle pulse from the start-bit detector
//   abort          : synchronous return to idle
//   busy           : frame in progress
//   start_strobe   : start-bit sample point
//   shift_strobe   : data-bit sample point (to the shift register)
//   stop_strobe    : stop-bit sample point
//   bit_index      : current data bit, 0 outside the data phase
//   frame_done     : one-cycle pulse after the stop sample
// All outputs decode registered state only; no input-to-output path.
module rx_bit_timer
  import rx_timer_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int SAMPLE_POINT = 5,
  parameter int DATA_BITS    = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start_detected,
  input  logic       abort,
  output logic       busy,
  output logic       start_strobe,
  output logic       shift_strobe,
  output logic       stop_strobe,
  output logic [3:0] bit_index,
  output logic       frame_done
);

  if (!timer_params_legal(CLKS_PER_BIT, SAMPLE_POINT, DATA_BITS)) begin : g_bad_params
    $error("rx_bit_timer: illegal CLKS_PER_BIT/SAMPLE_POINT/DATA_BITS");
  end

  localparam int            CW       = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] MAX_CYC  = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] SAMP_CYC = CW'(SAMPLE_POINT);
  localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);

  rx_timer_state_t state, next_state;
  logic [3:0]      bit_cnt, bit_cnt_next;
  logic [CW-1:0]   cyc_cnt;
  logic            bit_end;
  logic            sample;
  logic            cnt_clear, cnt_load, cnt_en;

  bit_cycle_counter #(.W(CW)) u_cyc_cnt (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (cnt_clear),
    .load_one (cnt_load),
    .en       (cnt_en),
    .max_val  (MAX_CYC),
    .count    (cyc_cnt),
    .at_max   (bit_end)
  );

  assign sample = (cyc_cnt == SAMP_CYC);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
    end else begin
      state   <= next_state;
      bit_cnt <= bit_cnt_next;
    end
  end

  // NOTE: every signal written here gets a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    next_state   = state;
    bit_cnt_next = bit_cnt;
    cnt_clear    = 1'b0;
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;
    busy         = (state != IDLE);
    start_strobe = 1'b0;
    shift_strobe = 1'b0;
    stop_strobe  = 1'b0;
    bit_index    = '0;
    frame_done   = 1'b0;

    case (state)
      START: start_strobe = sample;
      DATA: begin
        shift_strobe = sample;
        bit_index    = bit_cnt;
      end
      STOP:    stop_strobe = sample;
      DONE:    frame_done  = 1'b1;
      default: ;
    endcase

    // abort outranks everything, including a start pulse seen in IDLE.
    if (abort) begin
      next_state   = IDLE;
      bit_cnt_next = '0;
      cnt_clear    = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start_detected) begin
            next_state = START;
            cnt_load   = 1'b1;
          end else begin
            cnt_clear = 1'b1;
          end
        end
        START: begin
          cnt_en = 1'b1;
          if (bit_end) begin
            next_state   = DATA;
            bit_cnt_next = '0;
          end
        end
        DATA: begin
          cnt_en = 1'b1;
          if (bit_end) begin
            if (bit_cnt == LAST_BIT) begin
              next_state   = STOP;
              bit_cnt_next = '0;
            end else begin
              bit_cnt_next = 4'(bit_cnt + 4'd1);
            end
          end
        end
        STOP: begin
          if (sample) begin
            next_state = DONE;
            cnt_clear  = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end
        DONE: begin
          next_state = IDLE;
          cnt_clear  = 1'b1;
        end
        default: begin
          next_state   = IDLE;
          bit_cnt_next = '0;
          cnt_clear    = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_bit_timer.sv
// Self-checking bench for rx_bit_timer: a default-parameter instance and
// a minimum-parameter instance (2/2/1) run side by side. Outputs are
// compared every cycle against a frame-offset model, plus a vector
// table and hand-written frame sequences.
module tb_rx_bit_timer;

  localparam int CPB  = 10, SP  = 5, DB  = 8;
  localparam int BCPB = 2,  BSP = 2, BDB = 1;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  logic       m_start, m_abort, b_start, b_abort;
  logic       m_busy, m_st, m_sh, m_sp, m_dn;
  logic       b_busy, b_st, b_sh, b_sp, b_dn;
  logic [3:0] m_idx, b_idx;

  rx_bit_timer #(.CLKS_PER_BIT(CPB), .SAMPLE_POINT(SP), .DATA_BITS(DB)) dut (
    .clk(clk), .n_rst(n_rst), .start_detected(m_start), .abort(m_abort),
    .busy(m_busy), .start_strobe(m_st), .shift_strobe(m_sh),
    .stop_strobe(m_sp), .bit_index(m_idx), .frame_done(m_dn)
  );

  rx_bit_timer #(.CLKS_PER_BIT(BCPB), .SAMPLE_POINT(BSP), .DATA_BITS(BDB)) dut_b (
    .clk(clk), .n_rst(n_rst), .start_detected(b_start), .abort(b_abort),
    .busy(b_busy), .start_strobe(b_st), .shift_strobe(b_sh),
    .stop_strobe(b_sp), .bit_index(b_idx), .frame_done(b_dn)
  );

  int checks = 0;
  int errors = 0;

  // Model state per instance: whether a frame is live and how many
  // edges have passed since the edge that sampled its start pulse.
  bit act[2];
  int kk[2];

  logic [8:0] obs_m, obs_b;

  typedef struct {
    logic       start;
    logic       abort;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
    end
  endtask

  function automatic logic [8:0] mk(input bit busy, input bit st, input bit sh,
                                    input bit sp, input bit dn, input int idx);
    return {busy, st, sh, sp, dn, 4'(idx)};
  endfunction

  // Expected outputs k edges after the start edge: start bit occupies
  // k=0..cpb-1, data bits follow, stop is cut at its sample point, then
  // one DONE cycle at k = L.
  function automatic logic [8:0] model_out(input bit a, input int k, input int cpb,
                                           input int sp, input int db);
    int  l;
    bit  in_data;
    if (!a) return '0;
    l       = (db + 1) * cpb + sp;
    in_data = (k >= cpb) && (k < (db + 1) * cpb);
    return mk(1'b1, k == sp - 1, in_data && (k % cpb == sp - 1), k == l - 1,
              k == l, in_data ? (k - cpb) / cpb : 0);
  endfunction

  task automatic step_model(input int i, input logic s, input logic a,
                            input int cpb, input int sp, input int db);
    if (a) act[i] = 1'b0;
    else if (!act[i]) begin
      if (s) begin
        act[i] = 1'b1;
        kk[i]  = 0;
      end
    end else begin
      kk[i]++;
      if (kk[i] > (db + 1) * cpb + sp) act[i] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    step_model(0, m_start, m_abort, CPB, SP, DB);
    step_model(1, b_start, b_abort, BCPB, BSP, BDB);
    obs_m = {m_busy, m_st, m_sh, m_sp, m_dn, m_idx};
    obs_b = {b_busy, b_st, b_sh, b_sp, b_dn, b_idx};
    check("main_model", obs_m, model_out(act[0], kk[0], CPB, SP, DB));
    check("bnd_model", obs_b, model_out(act[1], kk[1], BCPB, BSP, BDB));
  endtask

  // Start pulse sampled at E0, then 96 more edges; timing landmarks are
  // checked against the nominal frame numbers.
  task automatic frame_run(input bit spurious, input string tag);
    int st_at = -1, sp_at = -1, dn_at = -1, idle_at = -1, dn_cnt = 0;
    int sh_at[$];
    int sh_idx[$];
    m_start = 1'b1;
    tick();
    m_start = 1'b0;
    for (int n = 1; n <= 96; n++) begin
      m_start = spurious && (n == 20 || n == 50);
      tick();
      m_start = 1'b0;
      if (m_st && st_at < 0) st_at = n;
      if (m_sh) begin
        sh_at.push_back(n);
        sh_idx.push_back(int'(m_idx));
      end
      if (m_sp && sp_at < 0) sp_at = n;
      if (m_dn) begin
        dn_cnt++;
        if (dn_at < 0) dn_at = n;
      end
      if (!m_busy && idle_at < 0) idle_at = n;
    end
    check({tag, "_start_edge"}, st_at, 4);
    check({tag, "_shift_count"}, sh_at.size(), 8);
    foreach (sh_at[i]) begin
      check({tag, "_shift_edge"}, sh_at[i], 14 + 10 * i);
      check({tag, "_shift_idx"}, sh_idx[i], i);
    end
    check({tag, "_stop_edge"}, sp_at, 94);
    check({tag, "_done_edge"}, dn_at, 95);
    check({tag, "_done_count"}, dn_cnt, 1);
    check({tag, "_idle_edge"}, idle_at, 96);
  endtask

  initial begin
    int quiet;
    n_rst   = 1'b0;
    m_start = 1'b0;
    m_abort = 1'b0;
    b_start = 1'b0;
    b_abort = 1'b0;
    act[0]  = 1'b0;
    act[1]  = 1'b0;
    kk[0]   = 0;
    kk[1]   = 0;

    tbl[0]  = '{1'b1, 1'b0, mk(1, 0, 0, 0, 0, 0)};
    tbl[1]  = '{1'b0, 1'b0, mk(1, 1, 0, 0, 0, 0)};
    tbl[2]  = '{1'b0, 1'b0, mk(1, 0, 0, 0, 0, 0)};
    tbl[3]  = '{1'b0, 1'b0, mk(1, 0, 1, 0, 0, 0)};
    tbl[4]  = '{1'b0, 1'b0, mk(1, 0, 0, 0, 0, 0)};
    tbl[5]  = '{1'b0, 1'b0, mk(1, 0, 0, 1, 0, 0)};
    tbl[6]  = '{1'b0, 1'b0, mk(1, 0, 0, 0, 1, 0)};
    tbl[7]  = '{1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0)};
    tbl[8]  = '{1'b1, 1'b1, mk(0, 0, 0, 0, 0, 0)};
    tbl[9]  = '{1'b1, 1'b0, mk(1, 0, 0, 0, 0, 0)};
    tbl[10] = '{1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0)};
    tbl[11] = '{1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0)};
    tbl[12] = '{1'b1, 1'b0, mk(1, 0, 0, 0, 0, 0)};
    tbl[13] = '{1'b1, 1'b0, mk(1, 1, 0, 0, 0, 0)};

    #12;
    check("reset_main", {m_busy, m_st, m_sh, m_sp, m_dn, m_idx}, 0);
    check("reset_bnd", {b_busy, b_st, b_sh, b_sp, b_dn, b_idx}, 0);
    @(negedge clk);
    n_rst = 1'b1;
    tick();

    // Minimum-parameter instance, cycle by cycle.
    foreach (tbl[i]) begin
      b_start = tbl[i].start;
      b_abort = tbl[i].abort;
      tick();
      check("bnd_table", obs_b, tbl[i].exp);
    end
    b_start = 1'b0;
    b_abort = 1'b0;
    for (int i = 0; i < 8; i++) tick();

    frame_run(1'b0, "nominal");
    frame_run(1'b1, "spurious");

    // Abort at E37, quiet through E39, fresh frame sampled at E40.
    m_start = 1'b1;
    tick();
    m_start = 1'b0;
    for (int n = 1; n <= 36; n++) tick();
    m_abort = 1'b1;
    tick();
    m_abort = 1'b0;
    check("abort_busy", m_busy, 0);
    quiet = 0;
    for (int n = 38; n <= 39; n++) begin
      tick();
      quiet += int'(m_busy) + int'(m_st) + int'(m_sh) + int'(m_sp) + int'(m_dn);
    end
    check("abort_quiet", quiet, 0);
    frame_run(1'b0, "after_abort");

    // Back-to-back: second start sampled in the first IDLE cycle.
    frame_run(1'b0, "b2b_first");
    frame_run(1'b0, "b2b_second");

    // Asynchronous reset in the middle of a frame.
    m_start = 1'b1;
    b_start = 1'b1;
    tick();
    m_start = 1'b0;
    b_start = 1'b0;
    for (int n = 0; n < 30; n++) tick();
    #2;
    n_rst = 1'b0;
    #1;
    act[0] = 1'b0;
    act[1] = 1'b0;
    check("midrst_main", {m_busy, m_st, m_sh, m_sp, m_dn, m_idx}, 0);
    check("midrst_bnd", {b_busy, b_st, b_sh, b_sp, b_dn, b_idx}, 0);
    @(negedge clk);
    n_rst = 1'b1;
    tick();

    // Random start/abort traffic on both instances.
    for (int n = 0; n < 4000; n++) begin
      m_start = ($urandom_range(0, 39) == 0);
      m_abort = ($urandom_range(0, 299) == 0);
      b_start = ($urandom_range(0, 3) == 0);
      b_abort = ($urandom_range(0, 49) == 0);
      tick();
    end
    m_start = 1'b0;
    m_abort = 1'b0;
    b_start = 1'b0;
    b_abort = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
